// File: rtl/fp_result_drain.sv
// Result-side collector: buffers FP results/flags in a small FIFO and streams them out
// with frame position, last marker, sticky exception flags and a sticky drop error.
module fp_result_drain #(
    parameter int WIDTH  = 8,
    parameter int FLAG_W = 6,
    parameter int DEPTH  = 4,
    parameter int N      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [WIDTH-1:0]           in_data_i,
    input  logic [FLAG_W-1:0]          in_flags_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [WIDTH-1:0]           out_data_o,
    output logic [FLAG_W-1:0]          out_flags_o,
    output logic [$clog2(N)-1:0]       out_idx_o,
    output logic                       out_last_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [FLAG_W-1:0]          sticky_flags_o,
    output logic                       drop_err_o,
    input  logic                       sticky_clr_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(N);
    localparam int EW = WIDTH + FLAG_W;

    logic [EW-1:0]     mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [FLAG_W-1:0] sticky_q, sticky_d;
    logic              drop_q, drop_d;
    logic              push, pop;

    // Handshake flags depend only on registered occupancy, never on the peer's valid/ready.
    assign in_ready_o  = (count_q != CW'(DEPTH));
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_q[gi] <= '0;
                end else if (push && (wr_ptr_q == AW'(gi))) begin
                    mem_q[gi] <= {in_data_i, in_flags_i};
                end
            end
        end
    endgenerate

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        idx_d    = idx_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            idx_d    = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        // A clear in the same cycle as a new event keeps the new event.
        sticky_d = (sticky_clr_i ? '0 : sticky_q) | (push ? in_flags_i : '0);
        drop_d   = (sticky_clr_i ? 1'b0 : drop_q) | (in_valid_i & ~in_ready_o);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            sticky_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            sticky_q <= sticky_d;
            drop_q   <= drop_d;
        end
    end

    assign {out_data_o, out_flags_o} = mem_q[rd_ptr_q];
    assign out_idx_o      = idx_q;
    assign out_last_o     = (idx_q == IW'(N - 1));
    assign count_o        = count_q;
    assign sticky_flags_o = sticky_q;
    assign drop_err_o     = drop_q;

endmodule
